// File: rtl/controle_rega_zonas_if.sv
// Bundle of the irrigation controller's request/command inputs and valve/status outputs.
//   asp, got      : raw per-zone sprinkler / drip requests
//   mef1          : global FSM state (2'b11 = irrigation allowed)
//   VE            : filling valve open
//   limpeza       : cleaning mode, inhibits irrigation
//   erro_clr      : single-cycle clear of the latched error
//   valvula_asp   : registered sprinkler valve per zone
//   valvula_got   : registered drip valve per zone
//   zona_ativa    : index of the granted zone
//   ocupado       : a zone is granted
//   erro/erro_cod : latched error flag and cause
// master drives the requests, slave (the controller) drives the valves/status.
interface controle_rega_zonas_if #(
    parameter int N_ZONAS = 4
);
    localparam int ZW = (N_ZONAS > 1) ? $clog2(N_ZONAS) : 1;

    logic [N_ZONAS-1:0] asp;
    logic [N_ZONAS-1:0] got;
    logic [1:0]         mef1;
    logic               VE;
    logic               limpeza;
    logic               erro_clr;
    logic [N_ZONAS-1:0] valvula_asp;
    logic [N_ZONAS-1:0] valvula_got;
    logic [ZW-1:0]      zona_ativa;
    logic               ocupado;
    logic               erro;
    logic [1:0]         erro_cod;

    modport master (
        output asp, got, mef1, VE, limpeza, erro_clr,
        input  valvula_asp, valvula_got, zona_ativa, ocupado, erro, erro_cod
    );

    modport slave (
        input  asp, got, mef1, VE, limpeza, erro_clr,
        output valvula_asp, valvula_got, zona_ativa, ocupado, erro, erro_cod
    );
endinterface

// File: rtl/controle_rega_zonas.sv
// Multi-zone irrigation controller.
// Debounces per-zone sprinkler (asp) and drip (got) requests, validates them
// against mef1 / VE / limpeza, and grants water to one zone at a time with
// round-robin fairness, a minimum hold of T_MIN and a yield point at T_MAX.
// Errors are latched (first cause wins) until erro_clr with no live condition.
//   clk   : system clock, rising edge
//   rst_n : asynchronous active-low reset
//   bus   : controle_rega_zonas_if.slave (requests in, valves/status out)

// One debounce lane: dout follows din after DEB_CICLOS consecutive differing samples.
module controle_rega_zonas_deb #(
    parameter int DEB_CICLOS = 4
) (
    input  logic clk,
    input  logic rst_n,
    input  logic din,
    output logic dout
);
    localparam int CW = $clog2(DEB_CICLOS + 1);

    logic [CW-1:0] cnt;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt  <= '0;
            dout <= 1'b0;
        end else if (din == dout) begin
            cnt <= '0;
        end else if (cnt == CW'(DEB_CICLOS - 1)) begin
            dout <= din;
            cnt  <= '0;
        end else begin
            cnt <= cnt + 1'b1;
        end
    end
endmodule

module controle_rega_zonas #(
    parameter int N_ZONAS    = 4,
    parameter int DEB_CICLOS = 4,
    parameter int T_MIN      = 16,
    parameter int T_MAX      = 64
) (
    input logic                   clk,
    input logic                   rst_n,
    controle_rega_zonas_if.slave  bus
);
    localparam int ZW = (N_ZONAS > 1) ? $clog2(N_ZONAS) : 1;
    localparam int HW = $clog2(T_MAX + 1);

    typedef enum logic [1:0] {OCIOSO, SELECIONA, REGANDO, ERRO} estado_t;

    estado_t            state, state_nxt;
    logic [ZW-1:0]      zona, zona_nxt;
    logic [ZW-1:0]      ptr, ptr_nxt;
    logic               modo, modo_nxt;        // 1 = sprinkler, 0 = drip
    logic [HW-1:0]      hold, hold_nxt;
    logic [1:0]         cod, cod_nxt;
    logic [N_ZONAS-1:0] v_asp, v_got, v_asp_nxt, v_got_nxt;

    logic [N_ZONAS-1:0] asp_raw, got_raw, asp_f, got_f, pend, oh_zona;
    logic               err_sensor, err_state, err_fill, err_any;
    logic [1:0]         err_cod_now;
    logic               hit, other_pend, modo_bit;
    logic [ZW-1:0]      idx, cand;

    assign asp_raw = bus.asp;
    assign got_raw = bus.got;

    controle_rega_zonas_deb #(.DEB_CICLOS(DEB_CICLOS)) u_deb_asp [N_ZONAS-1:0] (
        .clk(clk), .rst_n(rst_n), .din(asp_raw), .dout(asp_f)
    );
    controle_rega_zonas_deb #(.DEB_CICLOS(DEB_CICLOS)) u_deb_got [N_ZONAS-1:0] (
        .clk(clk), .rst_n(rst_n), .din(got_raw), .dout(got_f)
    );

    // A zone is a valid candidate only when exactly one mode is requested.
    assign pend = asp_f ^ got_f;

    // Error conditions; cleaning mode suppresses all of them.
    assign err_sensor = |(asp_f & got_f);
    assign err_state  = (|(asp_f | got_f)) && (bus.mef1 != 2'b11);
    assign err_fill   = bus.VE && (|(asp_f | got_f));
    assign err_any    = !bus.limpeza && (err_sensor || err_state || err_fill);
    assign err_cod_now = err_fill   ? 2'b11 :
                         err_sensor ? 2'b10 :
                         err_state  ? 2'b01 : 2'b00;

    assign oh_zona    = N_ZONAS'(1) << zona;
    assign other_pend = |(pend & ~oh_zona);
    assign modo_bit   = modo ? asp_f[zona] : got_f[zona];

    // Round-robin scan starting just after the last granted zone.
    always_comb begin
        hit  = 1'b0;
        idx  = ptr;
        cand = '0;
        for (int i = 1; i <= N_ZONAS; i++) begin
            cand = ZW'((int'(ptr) + i) % N_ZONAS);
            if (!hit && pend[cand]) begin
                hit = 1'b1;
                idx = cand;
            end
        end
    end

    always_comb begin
        state_nxt = state;
        zona_nxt  = zona;
        ptr_nxt   = ptr;
        modo_nxt  = modo;
        hold_nxt  = hold;
        cod_nxt   = cod;
        v_asp_nxt = '0;
        v_got_nxt = '0;

        case (state)
            OCIOSO: begin
                if (bus.mef1 == 2'b11 && |pend) state_nxt = SELECIONA;
            end
            SELECIONA: begin
                if (hit) begin
                    zona_nxt  = idx;
                    ptr_nxt   = idx;
                    modo_nxt  = asp_f[idx];
                    hold_nxt  = '0;
                    state_nxt = REGANDO;
                end else begin
                    state_nxt = OCIOSO;
                end
            end
            REGANDO: begin
                if (hold != HW'(T_MAX)) hold_nxt = hold + 1'b1;
                // A dropped request is still watered until the minimum hold expires.
                if ((hold >= HW'(T_MIN - 1) && !modo_bit) ||
                    (hold >= HW'(T_MAX - 1) && other_pend))
                    state_nxt = SELECIONA;
            end
            ERRO: begin
                if (bus.erro_clr && !err_any) begin
                    state_nxt = OCIOSO;
                    cod_nxt   = 2'b00;
                end
            end
            default: state_nxt = OCIOSO;
        endcase

        // Cleaning overrides everything except an already latched error;
        // otherwise the first error seen wins and is not overwritten.
        if (bus.limpeza) begin
            if (state != ERRO) state_nxt = OCIOSO;
        end else if (err_any && state != ERRO) begin
            state_nxt = ERRO;
            cod_nxt   = err_cod_now;
        end

        if (state_nxt == REGANDO) begin
            if (modo_nxt) v_asp_nxt = N_ZONAS'(1) << zona_nxt;
            else          v_got_nxt = N_ZONAS'(1) << zona_nxt;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= OCIOSO;
            zona  <= '0;
            ptr   <= ZW'(N_ZONAS - 1);
            modo  <= 1'b0;
            hold  <= '0;
            cod   <= 2'b00;
            v_asp <= '0;
            v_got <= '0;
        end else begin
            state <= state_nxt;
            zona  <= zona_nxt;
            ptr   <= ptr_nxt;
            modo  <= modo_nxt;
            hold  <= hold_nxt;
            cod   <= cod_nxt;
            v_asp <= v_asp_nxt;
            v_got <= v_got_nxt;
        end
    end

    assign bus.valvula_asp = v_asp;
    assign bus.valvula_got = v_got;
    assign bus.zona_ativa  = zona;
    assign bus.ocupado     = (state == REGANDO);
    assign bus.erro        = (state == ERRO);
    assign bus.erro_cod    = cod;
endmodule

// File: tb/tb_controle_rega_zonas.sv
// Directed bench for controle_rega_zonas (N_ZONAS=4, DEB=4, T_MIN=16, T_MAX=64).
module tb_controle_rega_zonas;
    logic clk = 1'b0;
    logic rst_n = 1'b0;
    int   n_pass = 0;
    int   n_fail = 0;
    int   n_total = 0;

    controle_rega_zonas_if #(.N_ZONAS(4)) bus ();

    controle_rega_zonas #(
        .N_ZONAS(4), .DEB_CICLOS(4), .T_MIN(16), .T_MAX(64)
    ) dut (
        .clk(clk), .rst_n(rst_n), .bus(bus)
    );

    always #5 clk = ~clk;

    task automatic step(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_total++;
        assert (obs === exp) n_pass++;
        else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation time limit expired");
        $fatal(1, "timeout");
    end

    initial begin
        bus.asp = '0; bus.got = '0; bus.mef1 = 2'b11; bus.VE = 1'b0;
        bus.limpeza = 1'b0; bus.erro_clr = 1'b0;

        // Reset values
        step(2);
        chk("rst_asp",  32'(bus.valvula_asp), 32'h0);
        chk("rst_got",  32'(bus.valvula_got), 32'h0);
        chk("rst_ocup", 32'(bus.ocupado), 32'h0);
        chk("rst_erro", 32'(bus.erro), 32'h0);
        chk("rst_cod",  32'(bus.erro_cod), 32'h0);
        chk("rst_zona", 32'(bus.zona_ativa), 32'h0);
        rst_n = 1'b1;
        step(1);

        // Zone 2 sprinkler: grant after 6 edges, minimum hold after drop
        bus.asp = 4'b0100;
        step(5);
        chk("t1_sel_closed", 32'(bus.valvula_asp), 32'h0);
        step(1);
        chk("t1_grant", 32'(bus.valvula_asp), 32'h4);
        chk("t1_zona", 32'(bus.zona_ativa), 32'h2);
        chk("t1_ocup", 32'(bus.ocupado), 32'h1);
        step(3);                        // hold counter = 3
        bus.asp = 4'b0000;
        step(12);                       // hold counter = 15
        chk("t1_tmin_hold", 32'(bus.valvula_asp), 32'h4);
        step(1);
        chk("t1_release", 32'(bus.valvula_asp), 32'h0);
        chk("t1_rel_ocup", 32'(bus.ocupado), 32'h0);
        step(1);
        chk("t1_zona_held", 32'(bus.zona_ativa), 32'h2);

        // Zones 0 and 1 drip held: 64-cycle turns with one idle cycle between
        bus.got = 4'b0011;
        step(6);
        chk("t2_z0_grant", 32'(bus.valvula_got), 32'h1);
        chk("t2_z0_zona", 32'(bus.zona_ativa), 32'h0);
        step(63);
        chk("t2_z0_last", 32'(bus.valvula_got), 32'h1);
        step(1);
        chk("t2_gap1_got", 32'(bus.valvula_got), 32'h0);
        chk("t2_gap1_asp", 32'(bus.valvula_asp), 32'h0);
        step(1);
        chk("t2_z1_grant", 32'(bus.valvula_got), 32'h2);
        chk("t2_z1_zona", 32'(bus.zona_ativa), 32'h1);
        step(63);
        chk("t2_z1_last", 32'(bus.valvula_got), 32'h2);
        step(1);
        chk("t2_gap2", 32'(bus.valvula_got), 32'h0);
        step(1);
        chk("t2_z0_again", 32'(bus.valvula_got), 32'h1);
        bus.got = 4'b0000;
        step(25);
        chk("t2_idle", 32'(bus.ocupado), 32'h0);

        // Zone 1 sprinkler, then filling valve opens
        bus.asp = 4'b0010;
        step(6);
        chk("t3_grant", 32'(bus.valvula_asp), 32'h2);
        chk("t3_zona", 32'(bus.zona_ativa), 32'h1);
        bus.VE = 1'b1;
        step(1);
        chk("t3_err_valve", 32'(bus.valvula_asp), 32'h0);
        chk("t3_erro", 32'(bus.erro), 32'h1);
        chk("t3_cod", 32'(bus.erro_cod), 32'h3);
        bus.erro_clr = 1'b1;
        step(1);
        bus.erro_clr = 1'b0;
        chk("t3_clr_ignored", 32'(bus.erro), 32'h1);
        chk("t3_cod_kept", 32'(bus.erro_cod), 32'h3);
        bus.VE = 1'b0;
        bus.asp = 4'b0000;
        bus.erro_clr = 1'b1;
        step(1);
        bus.erro_clr = 1'b0;
        chk("t3_cleared", 32'(bus.erro), 32'h0);
        chk("t3_cod_clr", 32'(bus.erro_cod), 32'h0);
        step(30);
        chk("t3_idle", 32'(bus.ocupado), 32'h0);

        // Zone 3 asp+got with mef1=01: sensor outranks state
        bus.mef1 = 2'b01;
        bus.asp = 4'b1000;
        bus.got = 4'b1000;
        step(4);
        chk("t4_pre_err", 32'(bus.erro), 32'h0);
        step(1);
        chk("t4_erro", 32'(bus.erro), 32'h1);
        chk("t4_cod", 32'(bus.erro_cod), 32'h2);
        bus.asp = 4'b0000;
        bus.got = 4'b0000;
        bus.mef1 = 2'b11;
        step(5);
        bus.erro_clr = 1'b1;
        step(1);
        bus.erro_clr = 1'b0;
        chk("t4_cleared", 32'(bus.erro), 32'h0);

        // 2-cycle glitch on zone 0: filtered away
        bus.asp = 4'b0001;
        step(2);
        bus.asp = 4'b0000;
        step(8);
        chk("t5_glitch_ocup", 32'(bus.ocupado), 32'h0);
        chk("t5_glitch_asp", 32'(bus.valvula_asp), 32'h0);
        chk("t5_glitch_erro", 32'(bus.erro), 32'h0);

        // Cleaning mode mid-irrigation
        bus.asp = 4'b0100;
        step(6);
        chk("t5_grant", 32'(bus.valvula_asp), 32'h4);
        bus.limpeza = 1'b1;
        step(1);
        chk("t5_limp_asp", 32'(bus.valvula_asp), 32'h0);
        chk("t5_limp_erro", 32'(bus.erro), 32'h0);
        step(3);
        chk("t5_limp_hold", 32'(bus.ocupado), 32'h0);
        bus.limpeza = 1'b0;
        step(2);
        chk("t5_regrant", 32'(bus.valvula_asp), 32'h4);

        // Asynchronous reset mid-irrigation
        #2;
        rst_n = 1'b0;
        #1;
        chk("t6_asp", 32'(bus.valvula_asp), 32'h0);
        chk("t6_ocup", 32'(bus.ocupado), 32'h0);
        chk("t6_zona", 32'(bus.zona_ativa), 32'h0);
        chk("t6_erro", 32'(bus.erro), 32'h0);
        step(1);
        rst_n = 1'b1;
        step(5);
        chk("t6_refilter", 32'(bus.valvula_asp), 32'h0);
        step(1);
        chk("t6_regrant", 32'(bus.valvula_asp), 32'h4);
        chk("t6_onehot", 32'(bus.valvula_got), 32'h0);

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end
endmodule

// File: doc/controle_rega_zonas.md
# controle_rega_zonas

Multi-zone irrigation controller and validator for the irrigation FSM path. Takes per-zone sprinkler (asp) and drip (got) requests, debounces them, checks them against the global FSM state (mef1) and the filling valve (VE), and grants water to one zone at a time with round-robin fairness and minimum/maximum hold times. Errors are latched until explicitly cleared. It drives the per-zone valves directly and replaces single-channel combinational validation.

## Interface
- N_ZONAS, 4: number of zones; must be ≥2.
- DEB_CICLOS, 4: consecutive identical samples needed to change a filtered request; ≥1.
- T_MIN, 16: minimum cycles a granted zone stays open; ≥1.
- T_MAX, 64: cycles after which the active zone yields if another zone is pending; must be ≥ T_MIN.

One clock; reset is asynchronous and active-low.
- clk  in  1  system clock; all state on the rising edge.
- rst_n  in  1  asynchronous active-low reset.
- asp  in  N_ZONAS  raw sprinkler request, one bit per zone.
- got  in  N_ZONAS  raw drip request, one bit per zone.
- mef1  in  2  global FSM state; 2'b11 = irrigation allowed.
- VE  in  1  filling valve open.
- limpeza  in  1  cleaning mode; inhibits all irrigation.
- erro_clr  in  1  single-cycle clear of the latched error.
- valvula_asp  out  N_ZONAS  sprinkler valve per zone; registered.
- valvula_got  out  N_ZONAS  drip valve per zone; registered.
- zona_ativa  out  clog2(N_ZONAS)  index of the granted zone; holds its last value when idle.
- ocupado  out  1  a zone is currently granted.
- erro  out  1  latched error flag.
- erro_cod  out  2  latched cause: 01 = state, 10 = sensor, 11 = filling, 00 = none.

## Operation
- Debounce, per zone and per bit: a sample counter resets whenever raw equals filtered. The filtered bit takes the raw value when DEB_CICLOS consecutive samples differ from it. All later logic uses only the filtered asp_f and got_f.
- Error conditions, evaluated every cycle while limpeza=0:
  - sensor: any zone with asp_f & got_f.
  - state: any filtered request while mef1≠2'b11.
  - filling: VE=1 while any filtered request is present.
- If several conditions are true in the same cycle, priority is filling > sensor > state.
- FSM states: OCIOSO, SELECIONA, REGANDO, ERRO.
- OCIOSO: all valves are 0. Goes to SELECIONA when mef1=11, limpeza=0, no error condition, and some zone has exactly one of asp_f/got_f set.
- SELECIONA (one cycle, valves 0): scans from ptr+1 round-robin for the first pending zone. On a hit it latches the zone into zona_ativa and ptr, latches the mode (asp or got), clears the hold counter and goes to REGANDO. With no hit it returns to OCIOSO.
- REGANDO: only the latched zone/mode valve is 1; ocupado=1. The hold counter increments and saturates at T_MAX. The zone is released to SELECIONA when:
  - counter ≥ T_MIN−1 and the latched mode bit of the active zone is 0, or
  - counter ≥ T_MAX−1 and any other zone is pending.
- A request that drops before T_MIN is still watered until T_MIN.
- Any error condition, from any state except ERRO: go to ERRO. On entry erro=1, erro_cod is latched, and all valves are 0. The first error wins; erro_cod is not overwritten while in ERRO.
- ERRO: exits to OCIOSO on erro_clr=1 only if no error condition is true in that cycle; this clears erro and erro_cod. If a condition is still true, erro_clr is ignored.
- limpeza=1: all valves are 0 next edge, FSM goes to OCIOSO (ERRO is kept if already in it), and no new errors are raised.
- At most one bit across valvula_asp|valvula_got is ever 1.

## Timing
- Reset values:
  - valvula_asp = 0, valvula_got = 0, ocupado = 0, erro = 0, erro_cod = 00, zona_ativa = 0.
  - ptr = N_ZONAS−1, so the first scan starts at zone 0.
  - FSM = OCIOSO; all filtered bits 0; all counters 0.
- Grant latency: a raw request first sampled at edge k gives a filtered request at edge k+DEB_CICLOS−1. SELECIONA runs at edge k+DEB_CICLOS and the valve is 1 after edge k+DEB_CICLOS+1.
- Error latency: erro rises and valves drop on the edge after the condition is seen on filtered signals.
- Zone switch is break-before-make: exactly one cycle with all valves 0, in SELECIONA.
- A reset asserted mid-irrigation closes all valves immediately (asynchronous) and restores the reset values.

## Test plan
- Zone 2 asp raw=1 held, mef1=11, N=4, DEB=4: valvula_asp=4'b0100 after 6 edges and zona_ativa=2. Drop asp at counter 3: valve stays 1 until counter reaches 15, then 0.
- Zones 0 and 1 got held continuously: zone 0 is granted for 64 cycles, 1 idle cycle, then zone 1 for 64, 1 idle, then zone 0 again.
- Zone 1 asp=1 while in REGANDO, then VE=1: next edge all valves 0, erro=1, erro_cod=11. erro_clr with VE still 1 is ignored; VE=0 then erro_clr gives erro=0 and erro_cod=00.
- Zone 3 asp and got both 1 with mef1=01: erro_cod=10, because sensor outranks state.
- 2-cycle glitch on asp zone 0: no grant, no error. limpeza=1 mid-irrigation: valves 0 next edge, erro stays 0.
- rst_n low mid-irrigation: valves 0 immediately and all outputs at reset values.
